// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg
// Shared definitions for the instruction-fetch queue:
//   XLEN_DEF     - default address/PC width
//   RESET_PC_DEF - default fetch address after reset
//   NOP_INST     - canonical RV32 NOP (addi x0, x0, 0)
//   fetch_entry_t - one queue entry {pc, inst, filled}
package fetch_queue_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [31:0]         inst;
    logic                filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if
// Bundles the fetch front-end channels:
//   imem request  : imem_req_valid/imem_req_addr (out of the queue), imem_req_ready (in)
//   imem response : imem_resp_valid/imem_resp_data (in, in request order)
//   redirect      : redirect_valid/redirect_pc (in)
//   dequeue       : deq_valid/deq_pc/deq_inst (out), deq_ready (in)
// master = the fetch queue, slave = the environment (memory + decode).
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            deq_valid;
  logic [XLEN-1:0] deq_pc;
  logic [31:0]     deq_inst;
  logic            deq_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output deq_valid, deq_pc, deq_inst,
    input  deq_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  deq_valid, deq_pc, deq_inst,
    output deq_ready
  );
endinterface

// File: rtl/fetch_queue_ptr.sv
// fetch_queue_ptr
// Wrap-around queue pointer. The extra MSB (PW = log2(DEPTH)+1) lets the
// owner tell a full queue from an empty one.
//   clk, rst  - clock, asynchronous active-high reset (pointer -> 0)
//   inc       - advance by one
//   load      - load load_val (takes precedence over inc)
//   ptr       - current pointer value
module fetch_queue_ptr #(
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          load,
  input  logic [PW-1:0] load_val,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ptr <= '0;
    else if (load) ptr <= load_val;
    else if (inc)  ptr <= ptr + PW'(1);
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
// Decoupled instruction-fetch front end. Issues sequential word-aligned
// fetch addresses, reserves one entry per request, fills entries from
// in-order responses and hands {pc, inst} to decode. A redirect empties the
// queue and discards every response still in flight.
//   clk, rst   - clock, asynchronous active-high reset
//   bus        - fetch_queue_if.master (imem request/response, redirect, dequeue)
// Optional (FETCH_QUEUE_STATS_EN defined): saturating 32-bit counters
//   stat_flush_cnt - redirects seen
//   stat_drop_cnt  - responses discarded
//   stat_stall_cnt - cycles with the queue full and nothing to dequeue
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
`ifdef FETCH_QUEUE_STATS_EN
  output logic [31:0] stat_flush_cnt,
  output logic [31:0] stat_drop_cnt,
  output logic [31:0] stat_stall_cnt,
`endif
  fetch_queue_if.master bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]   alloc_ptr, fill_ptr, head_ptr;
  logic [PW-1:0]   reserved, outstanding, drop_cnt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic [DEPTH-1:0] filled_q;
  fetch_entry_t    head_e;

  logic redir, req_valid, req_fire, drop_any, resp_take, resp_drop;
  logic deq_valid_w, deq_fire;

  assign redir       = bus.redirect_valid;
  assign reserved    = alloc_ptr - head_ptr;
  assign outstanding = alloc_ptr - fill_ptr;
  assign drop_any    = (drop_cnt != '0);

  assign req_valid = !redir && (reserved < PW'(DEPTH));
  assign req_fire  = req_valid && bus.imem_req_ready;

  // A response is consumed only when no stale responses remain to be
  // skipped; during a redirect it is always stale.
  assign resp_take = bus.imem_resp_valid && !drop_any && !redir;
  assign resp_drop = bus.imem_resp_valid && (drop_any || redir);

  assign head_e = '{pc:     XLEN_DEF'(pc_mem[head_ptr[IW-1:0]]),
                    inst:   inst_mem[head_ptr[IW-1:0]],
                    filled: filled_q[head_ptr[IW-1:0]]};

  assign deq_valid_w = head_e.filled && (head_ptr != fill_ptr);
  assign deq_fire    = deq_valid_w && bus.deq_ready && !redir;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.deq_valid      = deq_valid_w;
  // Gate with valid so the head view reads as zero out of reset, where the
  // payload storage itself is never initialised.
  assign bus.deq_pc         = deq_valid_w ? XLEN'(head_e.pc) : '0;
  assign bus.deq_inst       = deq_valid_w ? head_e.inst : '0;

  // On redirect all three pointers collapse onto alloc_ptr (queue empty).
  fetch_queue_ptr #(.PW(PW)) u_alloc_ptr (
    .clk(clk), .rst(rst), .inc(req_fire), .load(redir),
    .load_val(alloc_ptr), .ptr(alloc_ptr)
  );
  fetch_queue_ptr #(.PW(PW)) u_fill_ptr (
    .clk(clk), .rst(rst), .inc(resp_take), .load(redir),
    .load_val(alloc_ptr), .ptr(fill_ptr)
  );
  fetch_queue_ptr #(.PW(PW)) u_head_ptr (
    .clk(clk), .rst(rst), .inc(deq_fire), .load(redir),
    .load_val(alloc_ptr), .ptr(head_ptr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
      filled_q <= '0;
    end else begin
      if (redir)         fetch_pc <= bus.redirect_pc & ~XLEN'(3);
      else if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);

      // Everything still in flight becomes stale; a response arriving in
      // this very cycle is already one of them, hence the subtraction.
      if (redir)
        drop_cnt <= drop_cnt + outstanding - PW'(bus.imem_resp_valid);
      else if (bus.imem_resp_valid && drop_any)
        drop_cnt <= drop_cnt - PW'(1);

      if (req_fire)  filled_q[alloc_ptr[IW-1:0]] <= 1'b0;
      if (resp_take) filled_q[fill_ptr[IW-1:0]]  <= 1'b1;
    end
  end

  // Entry payload: written only, never reset.
  always_ff @(posedge clk) begin
    if (req_fire)  pc_mem[alloc_ptr[IW-1:0]]  <= fetch_pc;
    if (resp_take) inst_mem[fill_ptr[IW-1:0]] <= bus.imem_resp_data;
  end

`ifdef FETCH_QUEUE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_flush_cnt <= '0;
      stat_drop_cnt  <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (redir)     stat_flush_cnt <= sat_inc(stat_flush_cnt);
      if (resp_drop) stat_drop_cnt  <= sat_inc(stat_drop_cnt);
      if ((reserved == PW'(DEPTH)) && !deq_valid_w)
        stat_stall_cnt <= sat_inc(stat_stall_cnt);
    end
  end
`endif

endmodule
